// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Round-robin arbiter sharing one APB master port between NREQ local
//   requesters. Runs the APB SETUP/ACCESS sequence, honours pready wait
//   states, aborts on a wait-state timeout and reports a one-hot done pulse
//   with read data and error status. All outputs are registered.
//
// Ports
//   hclk, hresetn          clock, asynchronous active-low reset
//   req / req_write        per-requester request (held until done) and direction
//   req_addr / req_wdata   packed per-requester address and write data
//   req_sel                packed 3-bit slave select per requester (0 = decode error)
//   done                   one-cycle, one-hot completion pulse
//   rdata / err            read data / error, valid in the done cycle
//   busy                   high while in SETUP or ACCESS
//   paddr pwdata pwrite pselx penable prdata pready pslverr   APB master port
//
// state  | meaning
// IDLE   | arbitrating; decode errors complete here without a bus cycle
// SETUP  | APB setup phase, pselx driven, penable low
// ACCESS | APB access phase, penable high, waiting for pready or timeout

module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*3-1:0]    req_sel,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rdata,
  output logic                 err,
  output logic                 busy,
  output logic [AW-1:0]        paddr,
  output logic [DW-1:0]        pwdata,
  output logic                 pwrite,
  output logic [2:0]           pselx,
  output logic                 penable,
  input  logic [DW-1:0]        prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW:0]     NREQ_W = (IW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE    = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [7:0]      wait_cnt, wait_cnt_nxt;
  logic [NREQ-1:0] done_nxt;
  logic [DW-1:0]   rdata_nxt;
  logic            err_nxt;
  logic            busy_nxt;
  logic [AW-1:0]   paddr_nxt;
  logic [DW-1:0]   pwdata_nxt;
  logic            pwrite_nxt;
  logic [2:0]      pselx_nxt;
  logic            penable_nxt;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [IW-1:0]   win;
  logic [IW:0]     cand;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_write;
  logic [2:0]      w_sel;

  // The requester completing this cycle is masked so it cannot be re-granted
  // off its still-high req before it has had a chance to drop it.
  always_comb begin : arbitrate
    elig  = req & ~done;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && elig[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_comb begin : winner_mux
    w_addr  = '0;
    w_wdata = '0;
    w_write = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        w_addr  = req_addr[i*AW +: AW];
        w_wdata = req_wdata[i*DW +: DW];
        w_write = req_write[i];
        w_sel   = req_sel[i*3 +: 3];
      end
    end
  end

  // ptr always holds the index of the transfer in flight, so it doubles as
  // the done index for SETUP/ACCESS completions.
  always_comb begin : fsm_next
    state_nxt    = state;
    ptr_nxt      = ptr;
    wait_cnt_nxt = wait_cnt;
    done_nxt     = '0;
    rdata_nxt    = rdata;
    err_nxt      = 1'b0;
    paddr_nxt    = paddr;
    pwdata_nxt   = pwdata;
    pwrite_nxt   = pwrite;
    pselx_nxt    = pselx;
    penable_nxt  = 1'b0;
    case (state)
      IDLE: begin
        pselx_nxt = '0;
        if (found) begin
          ptr_nxt    = win;
          paddr_nxt  = w_addr;
          pwdata_nxt = w_wdata;
          pwrite_nxt = w_write;
          if (w_sel == 3'd0) begin
            done_nxt = ONE << win;
            err_nxt  = 1'b1;
          end else begin
            pselx_nxt = w_sel;
            state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        state_nxt    = ACCESS;
        penable_nxt  = 1'b1;
        wait_cnt_nxt = 8'(TIMEOUT - 1);
      end
      ACCESS: begin
        if (pready) begin
          state_nxt = IDLE;
          pselx_nxt = '0;
          done_nxt  = ONE << ptr;
          err_nxt   = pslverr;
          if (!pwrite) rdata_nxt = prdata;
        end else if (wait_cnt == 8'd0) begin
          state_nxt = IDLE;
          pselx_nxt = '0;
          done_nxt  = ONE << ptr;
          err_nxt   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 8'd1;
          penable_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pselx_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= IDLE;
      ptr      <= IW'(NREQ - 1);
      wait_cnt <= '0;
      done     <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      pselx    <= '0;
      penable  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      wait_cnt <= wait_cnt_nxt;
      done     <= done_nxt;
      rdata    <= rdata_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      paddr    <= paddr_nxt;
      pwdata   <= pwdata_nxt;
      pwrite   <= pwrite_nxt;
      pselx    <= pselx_nxt;
      penable  <= penable_nxt;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
//   Scoreboard bench for apb_req_arbiter. Stimulus raises a set of requests,
//   a round-level model predicts service order and results, and a monitor
//   checks every SETUP phase and done pulse against the queued expectations.
//   A slave process plays out the per-transfer wait/response script.

module tb_apb_req_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic                hclk = 1'b0;
  logic                hresetn = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_write = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*DW-1:0]  req_wdata = '0;
  logic [NREQ*3-1:0]   req_sel = '0;
  logic [NREQ-1:0]     done;
  logic [DW-1:0]       rdata;
  logic                err;
  logic                busy;
  logic [AW-1:0]       paddr;
  logic [DW-1:0]       pwdata;
  logic                pwrite;
  logic [2:0]          pselx;
  logic                penable;
  logic [DW-1:0]       prdata = '0;
  logic                pready = 1'b0;
  logic                pslverr = 1'b0;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel),
    .done(done), .rdata(rdata), .err(err), .busy(busy),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pselx(pselx),
    .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  // waits: number of pready-low ACCESS cycles before ready; -1 = slave hangs
  typedef struct {
    int             idx;
    bit             write;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [2:0]     sel;
    int             waits;
    bit             exp_err;
    logic [DW-1:0]  exp_rdata;
    int             start;
  } exp_t;

  typedef struct {
    int             waits;
    logic [DW-1:0]  rd;
    bit             slverr;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-requester transfer attributes for the next round
  bit             a_write [NREQ];
  logic [AW-1:0]  a_addr  [NREQ];
  logic [DW-1:0]  a_wdata [NREQ];
  logic [2:0]     a_sel   [NREQ];
  int             a_waits [NREQ];
  logic [DW-1:0]  a_rd    [NREQ];
  bit             a_slverr[NREQ];

  int            m_ptr   = NREQ - 1;
  logic [DW-1:0] m_rdata = '0;

  task automatic drive_attrs();
    for (int j = 0; j < NREQ; j++) begin
      req_write[j]           = a_write[j];
      req_addr[j*AW +: AW]   = a_addr[j];
      req_wdata[j*DW +: DW]  = a_wdata[j];
      req_sel[j*3 +: 3]      = a_sel[j];
    end
  endtask

  task automatic randomize_attrs();
    int r;
    for (int j = 0; j < NREQ; j++) begin
      a_write[j]  = 1'($urandom_range(0, 1));
      a_addr[j]   = $urandom;
      a_wdata[j]  = $urandom;
      a_sel[j]    = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      r = $urandom_range(0, 9);
      if (r <= 5)      a_waits[j] = r % 4;
      else if (r == 6) a_waits[j] = TIMEOUT - 1;
      else if (r == 7) a_waits[j] = -1;
      else             a_waits[j] = 0;
      a_rd[j]     = $urandom;
      a_slverr[j] = 1'($urandom_range(0, 1));
    end
  endtask

  // With every member of the set held and none re-raised, round-robin serves
  // each once, in cyclic order starting just after the last grant.
  task automatic push_round(input logic [NREQ-1:0] set);
    exp_t e;
    slv_t s;
    bit   first;
    int   j;
    int   last;
    first = 1'b1;
    last  = m_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (set[j]) begin
        e.idx   = j;
        e.write = a_write[j];
        e.addr  = a_addr[j];
        e.wdata = a_wdata[j];
        e.sel   = a_sel[j];
        e.waits = a_waits[j];
        e.start = first ? cyc : -1;
        first   = 1'b0;
        if (a_sel[j] == 3'd0) begin
          e.exp_err = 1'b1;
        end else begin
          s.waits  = a_waits[j];
          s.rd     = a_rd[j];
          s.slverr = a_slverr[j];
          slv_q.push_back(s);
          if (a_waits[j] < 0) begin
            e.exp_err = 1'b1;
          end else begin
            e.exp_err = a_slverr[j];
            if (!a_write[j]) m_rdata = a_rd[j];
          end
        end
        e.exp_rdata = m_rdata;
        exp_q.push_back(e);
        last = j;
      end
    end
    m_ptr = last;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (req != '0 && n < 400) begin
      @(negedge hclk);
      req = req & ~done;
      n++;
    end
    check({name, "_all_done"}, 64'(req), 64'(0));
    @(negedge hclk);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_round(input string name, input logic [NREQ-1:0] set);
    @(negedge hclk);
    drive_attrs();
    push_round(set);
    req = set;
    drain(name);
  endtask

  // ---------------- APB slave ----------------
  slv_t cur;
  int   s_cnt = 0;
  always @(negedge hclk) begin
    if (!hresetn) begin
      pready = 1'b0;
      s_cnt  = 0;
    end else if (pselx != 3'd0 && !penable) begin
      if (slv_q.size() != 0) cur = slv_q.pop_front();
      else begin cur.waits = 0; cur.rd = '0; cur.slverr = 1'b0; end
      s_cnt  = 0;
      pready = 1'b0;
    end else if (pselx != 3'd0 && penable) begin
      pready  = (cur.waits >= 0) && (s_cnt == cur.waits);
      prdata  = pready ? cur.rd : $urandom;
      pslverr = pready ? cur.slverr : 1'($urandom_range(0, 1));
      s_cnt++;
    end else begin
      pready  = 1'b0;
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t me;
  int   setup_cyc = 0;
  int   last_done = 0;
  int   g;
  always @(negedge hclk) begin
    if (hresetn) begin
      if (pselx != 3'd0 && !penable) begin
        check("setup_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          me = exp_q[0];
          g  = (me.start >= 0) ? me.start : last_done;
          check("setup_psel",   64'(pselx),  64'(me.sel));
          check("setup_paddr",  64'(paddr),  64'(me.addr));
          check("setup_pwdata", 64'(pwdata), 64'(me.wdata));
          check("setup_pwrite", 64'(pwrite), 64'(me.write));
          check("setup_cycle",  64'(cyc),    64'(g + 1));
          check("setup_busy",   64'(busy),   64'(1));
          setup_cyc = cyc;
        end
      end
      if (done != '0) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          me = exp_q.pop_front();
          g  = (me.start >= 0) ? me.start : last_done;
          check("done_onehot", 64'(done),  64'(NREQ'(1) << me.idx));
          check("done_err",    64'(err),   64'(me.exp_err));
          check("done_rdata",  64'(rdata), 64'(me.exp_rdata));
          check("done_bus_idle", 64'({pselx, penable, busy}), 64'(0));
          if (me.sel == 3'd0)   check("decerr_cycle",  64'(cyc), 64'(g + 1));
          else if (me.waits < 0) check("timeout_cycle", 64'(cyc), 64'(setup_cyc + TIMEOUT + 1));
          else                  check("done_cycle",    64'(cyc), 64'(setup_cyc + 2 + me.waits));
        end
        last_done = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    randomize_attrs();
    for (int j = 0; j < NREQ; j++) begin a_sel[j] = 3'd1; a_waits[j] = 0; end
    drive_attrs();
    repeat (3) @(negedge hclk);
    check("reset_outputs", 64'({done, err, busy, pwrite, pselx, penable}), 64'(0));
    check("reset_paddr",   64'(paddr),  64'(0));
    check("reset_rdata",   64'(rdata),  64'(0));
    hresetn = 1'b1;

    // contention from reset: grant order 0,1,2,3
    for (int j = 0; j < NREQ; j++) a_waits[j] = j % 2;
    run_round("contend", 4'b1111);

    // zero-wait write from requester 0
    a_write[0] = 1'b1; a_addr[0] = 32'h10; a_wdata[0] = 32'hA5A5_0001;
    a_sel[0] = 3'b001; a_waits[0] = 0; a_slverr[0] = 1'b0;
    run_round("write0", 4'b0001);

    // read with two wait states and slave error
    a_write[2] = 1'b0; a_addr[2] = 32'h40; a_sel[2] = 3'b010; a_waits[2] = 2;
    a_rd[2] = 32'hDEAD_BEEF; a_slverr[2] = 1'b1;
    run_round("read2", 4'b0100);

    // timeout on a hung slave
    a_write[1] = 1'b0; a_sel[1] = 3'b100; a_waits[1] = -1; a_rd[1] = 32'h1234_5678;
    run_round("timeout1", 4'b0010);

    // decode error on 3, with 0 pending behind it
    a_sel[3] = 3'd0; a_sel[0] = 3'b001; a_waits[0] = 0;
    run_round("decerr3", 4'b1001);

    // timeout boundary: ready on the last allowed cycle
    a_sel[2] = 3'b011; a_waits[2] = TIMEOUT - 1; a_write[2] = 1'b0; a_rd[2] = 32'h0BAD_F00D;
    run_round("edge_wait", 4'b0100);

    for (int r = 0; r < 40; r++) begin
      randomize_attrs();
      run_round("random", 4'($urandom_range(1, 15)));
    end

    // reset in the middle of an ACCESS phase
    randomize_attrs();
    a_sel[1] = 3'b101; a_waits[1] = -1; a_write[1] = 1'b0;
    a_sel[0] = 3'b001; a_waits[0] = 1;
    @(negedge hclk);
    drive_attrs();
    push_round(4'b0010);
    req = 4'b0010;
    n = 0;
    while (!penable && n < 20) begin @(negedge hclk); n++; end
    check("reach_access", 64'(penable), 64'(1));
    @(posedge hclk);
    #2 hresetn = 1'b0;
    #1;
    check("midrst_ctrl",   64'({done, err, busy, pwrite, pselx, penable}), 64'(0));
    check("midrst_paddr",  64'(paddr),  64'(0));
    check("midrst_pwdata", 64'(pwdata), 64'(0));
    check("midrst_rdata",  64'(rdata),  64'(0));
    exp_q.delete();
    slv_q.delete();
    m_ptr   = NREQ - 1;
    m_rdata = '0;
    req = 4'b0011;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    push_round(4'b0011);
    drain("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
